matmul_seq_ctrl: RTL and testbench

Serial sequencer for 3x3 matrix multiplication. Accepts A and B as an 18-beat byte stream (e.g. from a UART receive path) and computes C = A x B on a single time-shared multiply-accumulate unit, one product per cycle. Returns C as a 9-beat stream. Replaces the fully parallel 27-multiplier datapath where area matters, and interfaces on ready/valid handshakes.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matmul_seq_ctrl_if.sv | 29 ++
 rtl/matmul_mac.sv | 74 +++++++
 rtl/matmul_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg -- shared constants, counter widths, FSM state type and the
// element-addressing helper for the 3x3 serial matrix-multiply sequencer.
package matmul_pkg;

  localparam int DIM      = 3;   // matrix dimension
  localparam int NELEM    = 9;   // elements per matrix
  localparam int NLOAD    = 18;  // beats per load (A then B)

  localparam int LD_CNT_W = 5;
  localparam int IDX_W    = 2;
  localparam int OC_W     = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Row-major flat index of element [row][col] inside a 3x3 matrix.
  function automatic logic [LD_CNT_W-1:0] elem_idx(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
    return LD_CNT_W'(row) * LD_CNT_W'(DIM) + LD_CNT_W'(col);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if -- input and output byte streams of the sequencer.
//   in_valid/in_ready/in_data     : A/B element stream into the block
//   out_valid/out_ready/out_data  : C element stream out of the block
//   out_last                      : marks the c8 beat
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; the valid side keeps data (and last) stable until that edge.
// master = stream source / sink side (bench, UART path); slave = the sequencer.
interface matmul_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_mac.sv
// matmul_mac -- time-shared multiply-accumulate unit.
//   mul_en/mul_last : issue a*b this cycle; mul_last tags the k=2 product
//   clr             : synchronous clear of the pipeline and accumulator
//   res_valid       : one-cycle strobe, res_data holds a finished C element
// The product is registered before accumulation, so a finished element
// appears one cycle after its last operand pair was issued.
// Build option MATMUL_SAT_EN: saturate the sum to OUT_W bits; otherwise the
// sum is truncated (wraps) to OUT_W bits.
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mul_en,
  input  logic              mul_last,
  input  logic [DATA_W-1:0] a_op,
  input  logic [DATA_W-1:0] b_op,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data
);
  localparam int PROD_W = 2 * DATA_W;
  // Three full-scale products need two guard bits above PROD_W.
  localparam int ACC_W  = 2 * DATA_W + 2;

  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;
  logic              prod_last_q, prod_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum;

  always_comb begin
    prod_d      = PROD_W'(a_op) * PROD_W'(b_op);
    prod_vld_d  = mul_en;
    prod_last_d = mul_last;
    sum         = acc_q + ACC_W'(prod_q);
    acc_d       = acc_q;
    if (prod_vld_q) begin
      // The closing product finishes an element: hand sum out, restart at 0.
      acc_d = prod_last_q ? '0 : sum;
    end
    if (clr) begin
      prod_vld_d  = 1'b0;
      prod_last_d = 1'b0;
      acc_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      acc_q       <= acc_d;
    end
  end

  assign res_valid = prod_vld_q && prod_last_q && !clr;

  always_comb begin
`ifdef MATMUL_SAT_EN
    res_data = (|sum[ACC_W-1:OUT_W]) ? '1 : sum[OUT_W-1:0];
`else
    res_data = sum[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl -- serial 3x3 matrix-multiply sequencer C = A x B.
//   clk, rst (async, active low), abort (sync return to LOAD)
//   bus       : slave side of matmul_seq_ctrl_if (A/B in, C out streams)
//   busy      : high in COMPUTE and OUTPUT
//   done      : one-cycle pulse after the c8 handshake
//   state_dbg : current FSM state
// Flow: LOAD takes a0..a8,b0..b8; COMPUTE issues 27 products (k innermost,
// i outermost) into matmul_mac; OUTPUT streams c0..c8.
// Build option MATMUL_SAT_EN (inside matmul_mac): saturate C elements.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  matmul_seq_ctrl_if.slave   bus,
  output logic               busy,
  output logic               done,
  output state_e             state_dbg
);

  state_e                state_q, state_d;
  logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
  logic [OC_W-1:0]       wr_q, wr_d;   // next C slot the MAC result lands in
  logic [OC_W-1:0]       oc_q, oc_d;
  logic                  in_ready_q, in_ready_d;
  logic                  done_q, done_d;

  logic [DATA_W-1:0]     ab_q [NLOAD];  // A at 0..8, B at 9..17
  logic [OUT_W-1:0]      c_q  [NELEM];

  logic                  in_hs, out_hs, mul_en, res_valid;
  logic [OUT_W-1:0]      res_data;

  // in_ready_q is only ever high in LOAD, so it alone qualifies the load.
  assign in_hs  = bus.in_valid && in_ready_q;
  assign out_hs = (state_q == OUTPUT) && bus.out_ready;
  // i runs to 3 after the final product, which stops further issue.
  assign mul_en = (state_q == COMPUTE) && (i_q != IDX_W'(DIM));

  matmul_mac #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_mac (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (abort),
    .mul_en    (mul_en),
    .mul_last  (k_q == IDX_W'(DIM - 1)),
    .a_op      (ab_q[elem_idx(i_q, k_q)]),
    .b_op      (ab_q[LD_CNT_W'(NELEM) + elem_idx(k_q, j_q)]),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    wr_d     = wr_q;
    oc_d     = oc_q;
    done_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LD_CNT_W'(NLOAD - 1)) begin
            state_d  = COMPUTE;
            ld_cnt_d = '0;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            wr_d     = '0;
          end
        end
      end
      COMPUTE: begin
        if (mul_en) begin
          if (k_q == IDX_W'(DIM - 1)) begin
            k_d = '0;
            if (j_q == IDX_W'(DIM - 1)) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        if (res_valid) begin
          wr_d = wr_q + 1'b1;
          if (wr_q == OC_W'(NELEM - 1)) begin
            state_d = OUTPUT;
            oc_d    = '0;
          end
        end
      end
      OUTPUT: begin
        if (out_hs) begin
          if (oc_q == OC_W'(NELEM - 1)) begin
            state_d = LOAD;
            oc_d    = '0;
            done_d  = 1'b1;
          end else begin
            oc_d = oc_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (abort) begin
      state_d  = LOAD;
      ld_cnt_d = '0;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      wr_d     = '0;
      oc_d     = '0;
      done_d   = 1'b0;
    end
    // Registered so in_ready stays low in the first cycle out of reset.
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      ld_cnt_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wr_q       <= '0;
      oc_q       <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wr_q       <= wr_d;
      oc_q       <= oc_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  // Element storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_hs && !abort) ab_q[ld_cnt_q] <= bus.in_data;
    if (res_valid)       c_q[wr_q]      <= res_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_data  = (state_q == OUTPUT) ? c_q[oc_q] : '0;
  assign bus.out_last  = (state_q == OUTPUT) && (oc_q == OC_W'(NELEM - 1));
  assign busy          = (state_q != LOAD);
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  typedef struct packed {
    logic [8:0][7:0] a;
    logic [8:0][7:0] b;
    logic [8:0][7:0] c;
    int              gap;
    int              rdy;
  } vec_t;

  logic   clk;
  logic   rst;
  logic   abort;
  logic   busy;
  logic   done;
  state_e state_dbg;
  int     n_vec;
  int     n_err;
  int     done_cnt;

  matmul_seq_ctrl_if #(.DATA_W(8), .OUT_W(8)) bus ();

  matmul_seq_ctrl #(.DATA_W(8), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  // Reference: plain 3x3 product, reduced per build option.
  function automatic logic [8:0][7:0] ref_mul(input logic [8:0][7:0] a, input logic [8:0][7:0] b);
    logic [8:0][7:0] c;
    int sum;
    for (int r = 0; r < 3; r++) begin
      for (int col = 0; col < 3; col++) begin
        sum = 0;
        for (int k = 0; k < 3; k++) sum += int'(a[3*r+k]) * int'(b[3*k+col]);
`ifdef MATMUL_SAT_EN
        c[3*r+col] = (sum > 255) ? 8'hFF : 8'(sum);
`else
        c[3*r+col] = 8'(sum % 256);
`endif
      end
    end
    return c;
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic load_beats(input logic [17:0][7:0] ab, input int n, input int gap_pct);
    int guard;
    for (int bt = 0; bt < n; bt++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ab[bt];
      guard = 0;
      while (!bus.in_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 64) begin
        fail_now("in_ready_wait");
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic collect(input logic [8:0][7:0] exp, input int rdy_pct, input int n,
                         input bit abort_last);
    int beat, cyc;
    bit rdy, prev_rdy, have_prev;
    logic [7:0] prev_d;
    logic prev_l;
    beat = 0; cyc = 0; have_prev = 0; prev_rdy = 0; prev_d = '0; prev_l = 1'b0;
    while (beat < n && cyc < 400) begin
      rdy = ($urandom_range(0, 99) < rdy_pct);
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        check("done_in_output", 32'(done), 32'(0));
        if (have_prev && !prev_rdy) begin
          check("hold_data", 32'(bus.out_data), 32'(prev_d));
          check("hold_last", 32'(bus.out_last), 32'(prev_l));
        end
        prev_d = bus.out_data;
        prev_l = bus.out_last;
        if (rdy) begin
          check($sformatf("c%0d_data", beat), 32'(bus.out_data), 32'(exp[beat]));
          check($sformatf("c%0d_last", beat), 32'(bus.out_last), 32'(beat == 8));
          if (abort_last && beat == n - 1) abort = 1'b1;
          beat++;
        end
        have_prev = 1'b1;
        prev_rdy  = rdy;
      end else begin
        have_prev = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    abort         = 1'b0;
    if (beat < n) fail_now("out_beats");
  endtask

  task automatic finish_run(input bit exp_done);
    check("end_done", 32'(done), 32'(exp_done));
    check("end_in_ready", 32'(bus.in_ready), 32'(1));
    check("end_busy", 32'(busy), 32'(0));
    check("end_out_valid", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    #1;
    check("done_width", 32'(done), 32'(0));
    check("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(0));
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(bus.out_data), 32'(0));
    check({tag, "_out_last"}, 32'(bus.out_last), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl [4];
  int   c_rev [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  initial begin
    logic [8:0][7:0] ra, rb;
    int seen;
    n_vec = 0; n_err = 0; done_cnt = 0;
    rst = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    for (int e = 0; e < 9; e++) begin
      tbl[0].a[e] = 8'(e + 1);
      tbl[0].b[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
      tbl[0].c[e] = 8'(e + 1);
      tbl[1].a[e] = 8'(e + 1);
      tbl[1].b[e] = 8'(9 - e);
      tbl[1].c[e] = 8'(c_rev[e]);
      tbl[2].a[e] = 8'hFF;
      tbl[2].b[e] = 8'hFF;
`ifdef MATMUL_SAT_EN
      tbl[2].c[e] = 8'hFF;
`else
      tbl[2].c[e] = 8'h03;
`endif
      tbl[3].a[e] = tbl[1].a[e];
      tbl[3].b[e] = tbl[1].b[e];
      tbl[3].c[e] = tbl[1].c[e];
    end
    tbl[0].gap = 0;  tbl[0].rdy = 100;
    tbl[1].gap = 0;  tbl[1].rdy = 100;
    tbl[2].gap = 0;  tbl[2].rdy = 100;
    tbl[3].gap = 30; tbl[3].rdy = 50;

    // Reset values, then in_ready rises one edge after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    #1;
    check("rst_rel_in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    check("rst_rel_in_ready_up", 32'(bus.in_ready), 32'(1));
    check("rst_state", 32'(state_dbg), 32'(LOAD));

    // Table-driven runs.
    for (int t = 0; t < 4; t++) begin
      done_cnt = 0;
      load_beats({tbl[t].b, tbl[t].a}, 18, tbl[t].gap);
      if (t == 0) begin
        check("load_in_ready_drop", 32'(bus.in_ready), 32'(0));
        repeat (27) @(negedge clk);
        check("lat_t27_valid", 32'(bus.out_valid), 32'(0));
        check("lat_t27_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("lat_t28_valid", 32'(bus.out_valid), 32'(1));
      end
      collect(tbl[t].c, tbl[t].rdy, 9, 1'b0);
      finish_run(1'b1);
    end

    // Randomized matrices against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < 9; e++) begin
        ra[e] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
        rb[e] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      end
      done_cnt = 0;
      load_beats({rb, ra}, 18, $urandom_range(0, 40));
      collect(ref_mul(ra, rb), $urandom_range(50, 100), 9, 1'b0);
      finish_run(1'b1);
    end

    // Abort in the tenth COMPUTE cycle, then a fresh load.
    done_cnt = 0;
    load_beats({tbl[1].b, tbl[1].a}, 18, 0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_state", 32'(state_dbg), 32'(LOAD));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'(0));
    check("abort_no_done", 32'(done_cnt), 32'(0));
    load_beats({tbl[0].b, tbl[0].a}, 18, 0);
    collect(tbl[0].c, 100, 9, 1'b0);
    finish_run(1'b1);

    // Abort during a partial load discards it.
    done_cnt = 0;
    load_beats({tbl[2].b, tbl[2].a}, 7, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("pabort_in_ready", 32'(bus.in_ready), 32'(1));
    load_beats({tbl[1].b, tbl[1].a}, 18, 0);
    collect(tbl[1].c, 80, 9, 1'b0);
    finish_run(1'b1);

    // Abort together with the c8 handshake: no done pulse.
    done_cnt = 0;
    load_beats({tbl[0].b, tbl[0].a}, 18, 0);
    collect(tbl[0].c, 100, 9, 1'b1);
    finish_run(1'b0);

    // Reset during OUTPUT after 4 beats, then a full run from oc=0.
    done_cnt = 0;
    load_beats({tbl[1].b, tbl[1].a}, 18, 0);
    collect(tbl[1].c, 100, 4, 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    done_cnt = 0;
    load_beats({tbl[1].b, tbl[1].a}, 18, 10);
    collect(tbl[1].c, 70, 9, 1'b0);
    finish_run(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
